// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU among NREQ requesters,
// with a single registered response slot. Optional grant lock: ALU_ARB_LOCK_EN.
module alu_arbiter_lane #(
  parameter int IDW = 1,
  parameter int IDX = 0
) (
  input  logic           vld,
  input  logic           lock_valid,
  input  logic [IDW-1:0] lock_id,
  output logic           elig
);
  // A held lock masks every requester except its owner, idle or not.
  assign elig = vld && (!lock_valid || lock_id == IDW'(IDX));
endmodule

module alu_arbiter #(
  parameter  int NREQ  = 2,
  parameter  int WIDTH = 32,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*4-1:0]     req_ctrl,
  input  logic [NREQ-1:0]       req_lock,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [3:0]            alu_ctrl,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_zero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_err
);
  typedef struct packed {
    logic             vld;
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             err;
  } rsp_t;

  rsp_t                       rsp_q;
  logic [IDW-1:0]             rr_ptr, gnt_id, sel, idx;
  logic                       gnt, can_issue, illegal;
  logic [NREQ-1:0]            elig;
  logic [NREQ-1:0][WIDTH-1:0] a_v, b_v;
  logic [NREQ-1:0][3:0]       ctrl_v;
  logic                       lock_valid;
  logic [IDW-1:0]             lock_id;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign a_v[i]    = req_a[i*WIDTH +: WIDTH];
    assign b_v[i]    = req_b[i*WIDTH +: WIDTH];
    assign ctrl_v[i] = req_ctrl[i*4 +: 4];
    alu_arbiter_lane #(.IDW(IDW), .IDX(i)) u_lane (
      .vld        (req_valid[i]),
      .lock_valid (lock_valid),
      .lock_id    (lock_id),
      .elig       (elig[i])
    );
  end

  assign can_issue = !rsp_q.vld || rsp_ready;

  // Scan from the farthest offset down so the nearest eligible requester wins.
  always_comb begin
    gnt    = 1'b0;
    gnt_id = rr_ptr;
    idx    = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (elig[idx]) begin
        gnt    = 1'b1;
        gnt_id = idx;
      end
    end
    gnt = gnt && can_issue && rst_n;
  end

  always_comb begin
    req_ready = '0;
    if (gnt) req_ready[gnt_id] = 1'b1;
  end

  assign sel      = gnt ? gnt_id : rr_ptr;
  assign alu_a    = a_v[sel];
  assign alu_b    = b_v[sel];
  assign alu_ctrl = ctrl_v[sel];
  assign illegal  = alu_ctrl > 4'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q  <= '0;
      rr_ptr <= '0;
    end else if (gnt) begin
      rsp_q.vld    <= 1'b1;
      rsp_q.id     <= gnt_id;
      rsp_q.result <= illegal ? '0 : alu_result;
      rsp_q.zero   <= illegal | alu_zero;
      rsp_q.err    <= illegal;
      rr_ptr       <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
    end else if (rsp_ready) begin
      rsp_q.vld <= 1'b0;
    end
  end

`ifdef ALU_ARB_LOCK_EN
  logic           lock_q;
  logic [IDW-1:0] lock_id_q;

  // Every grant rewrites the lock: the owner's req_lock either renews or releases it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else if (gnt) begin
      lock_q    <= req_lock[gnt_id];
      lock_id_q <= gnt_id;
    end
  end
  assign lock_valid = lock_q;
  assign lock_id    = lock_id_q;
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign lock_valid  = 1'b0;
  assign lock_id     = '0;
`endif

  assign rsp_valid  = rsp_q.vld;
  assign rsp_id     = rsp_q.id;
  assign rsp_result = rsp_q.result;
  assign rsp_zero   = rsp_q.zero;
  assign rsp_err    = rsp_q.err;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_alu_arbiter;
  localparam int NREQ = 3, WIDTH = 32, IDW = 2;
`ifdef ALU_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0] req_valid, req_ready, req_lock;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ*4-1:0] req_ctrl;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result, rsp_result;
  logic [3:0] alu_ctrl;
  logic alu_zero, rsp_valid, rsp_ready, rsp_zero, rsp_err;
  logic [IDW-1:0] rsp_id;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl), .req_lock(req_lock),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .alu_zero(alu_zero), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err));

  // ALU stub: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT; garbage on illegal codes.
  function automatic logic [WIDTH-1:0] alu_fn(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic [3:0] c);
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return ($signed(a) < $signed(b)) ? 1 : 0;
      default: return 32'hDEADBEEF;
    endcase
  endfunction
  assign alu_result = alu_fn(alu_a, alu_b, alu_ctrl);
  assign alu_zero   = (alu_ctrl <= 4'd4) && (alu_result == '0);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int rr; bit vld; int id; logic [WIDTH-1:0] res; bit zero; bit err; bit lockv; int lockid;
  } mst_t;
  mst_t m, n;

  // Model: compare at the negedge, commit at the next posedge.
  always @(negedge clk) begin
    int g, sel, idx;
    bit can, hit;
    logic [3:0] c;
    logic [WIDTH-1:0] a, b;
    if (!rst_n) begin
      chk("m_rst_ready", req_ready, 0);
      chk("m_rst_valid", rsp_valid, 0);
      chk("m_rst_id", rsp_id, 0);
      chk("m_rst_result", rsp_result, 0);
      chk("m_rst_zero", rsp_zero, 0);
      chk("m_rst_err", rsp_err, 0);
      n = '{default: 0};
    end else begin
      can = !m.vld || rsp_ready;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m.rr + k) % NREQ;
        if (g < 0 && req_valid[idx] && (!m.lockv || idx == m.lockid)) g = idx;
      end
      hit = can && (g >= 0);
      sel = hit ? g : m.rr;
      a = req_a[sel*WIDTH +: WIDTH];
      b = req_b[sel*WIDTH +: WIDTH];
      c = req_ctrl[sel*4 +: 4];
      chk("m_req_ready", req_ready, hit ? (1 << g) : 0);
      chk("m_alu_a", alu_a, a);
      chk("m_alu_b", alu_b, b);
      chk("m_alu_ctrl", alu_ctrl, c);
      chk("m_rsp_valid", rsp_valid, m.vld);
      if (m.vld) begin
        chk("m_rsp_id", rsp_id, m.id);
        chk("m_rsp_result", rsp_result, m.res);
        chk("m_rsp_zero", rsp_zero, m.zero);
        chk("m_rsp_err", rsp_err, m.err);
      end
      n = m;
      if (hit) begin
        n.vld = 1; n.id = g; n.err = c > 4'd4;
        n.res = n.err ? '0 : alu_fn(a, b, c);
        n.zero = (n.res == '0);
        n.rr = (g + 1) % NREQ;
        n.lockv = LOCK && req_lock[g];
        n.lockid = g;
      end else if (rsp_ready) begin
        n.vld = 0;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m = '{default: 0};
    else m = n;
  end

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [3:0] c);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_ctrl[i*4 +: 4] = c;
  endtask
  task automatic step(); @(posedge clk); #1; endtask
  task automatic half(); @(negedge clk); #1; endtask

  logic [2:0] exp6 [5];
  int prev;

  initial begin
`ifdef ALU_ARB_LOCK_EN
    exp6 = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001};
`else
    exp6 = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
`endif
    req_valid = '0; req_lock = '0; req_a = '0; req_b = '0; req_ctrl = '0; rsp_ready = 1'b1;
    req_valid = 3'b011;
    half();
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    // Reset release, single request
    step(); rst_n = 1'b1; set_req(0, 5, 3, 4'd0); req_valid = 3'b001;
    half(); chk("t1_ready", req_ready, 3'b001);
    // Alternation with SLT on req0 and SUB on req1
    step(); set_req(0, -1, 1, 4'd4); set_req(1, 7, 7, 4'd1); req_valid = 3'b011;
    half();
    chk("t1_valid", rsp_valid, 1); chk("t1_id", rsp_id, 0);
    chk("t1_result", rsp_result, 8); chk("t1_zero", rsp_zero, 0);
    chk("t2_gnt0", req_ready, 3'b010);
    for (int i = 1; i <= 3; i++) begin
      step(); half();
      prev = (i % 2 == 1) ? 1 : 0;
      chk("t2_id", rsp_id, prev);
      chk("t2_result", rsp_result, prev == 1 ? 0 : 1);
      chk("t2_zero", rsp_zero, prev);
      chk("t2_gnt", req_ready, (i % 2 == 0) ? 3'b010 : 3'b001);
    end
    // Backpressure hold
    step(); rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      half();
      chk("t3_ready", req_ready, 0); chk("t3_valid", rsp_valid, 1);
      chk("t3_id", rsp_id, 0); chk("t3_result", rsp_result, 1);
      if (i < 2) step();
    end
    step(); rsp_ready = 1'b1;
    half(); chk("t3_regrant", req_ready, 3'b010);
    // Illegal control code, then a legal op
    step(); set_req(1, 1, 2, 4'b1010); req_valid = 3'b010;
    half(); chk("t4_gnt", req_ready, 3'b010); chk("t4_sub_zero", rsp_zero, 1);
    step(); set_req(1, 1, 2, 4'd0);
    half();
    chk("t4_err", rsp_err, 1); chk("t4_result", rsp_result, 0);
    chk("t4_zero", rsp_zero, 1); chk("t4_id", rsp_id, 1);
    step(); req_valid = '0; rsp_ready = 1'b0;
    half(); chk("t4_legal_err", rsp_err, 0); chk("t4_legal_result", rsp_result, 3);
    // Async reset with a held response
    step(); req_valid = 3'b011;
    half(); chk("t5_pre_valid", rsp_valid, 1);
    #1 rst_n = 1'b0;
    #1 chk("t5_async_valid", rsp_valid, 0); chk("t5_async_ready", req_ready, 0);
    step(); rst_n = 1'b1; rsp_ready = 1'b1;
    half(); chk("t5_first_gnt", req_ready, 3'b001);
    // Lock sequence (expectation depends on build)
    for (int k = 0; k < 5; k++) begin
      step(); req_lock = (k < 3) ? 3'b010 : 3'b000;
      half(); chk("t6_gnt", req_ready, exp6[k]);
    end
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      rst_n = ($urandom_range(99) != 0);
      req_valid = NREQ'($urandom);
      req_lock = ($urandom_range(3) == 0) ? NREQ'($urandom) : '0;
      rsp_ready = ($urandom_range(3) != 0);
      for (int r = 0; r < NREQ; r++)
        set_req(r, $urandom_range(3) == 0 ? WIDTH'($urandom_range(3)) : $urandom, $urandom,
                ($urandom_range(7) == 0) ? 4'($urandom) : 4'($urandom_range(4)));
    end
    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
